// File: rtl/gr_bin_counter.sv
// Free-running Gray-code up-counter; binary and Gray outputs are registered together, one step per clk, no stall.
// Define GR_BIN_COUNTER_TC_EN to add the registered terminal-count output tc.
module gr_bin_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    output logic [WIDTH-1:0] gray_count,
    output logic [WIDTH-1:0] bin_count
`ifdef GR_BIN_COUNTER_TC_EN
    ,
    output logic             tc
`endif
);

    logic [WIDTH-1:0] bin_next;
    logic [WIDTH-1:0] gray_next;

    // Gray is encoded from the next binary value so both registers land on the same edge.
    always_comb begin
        bin_next  = bin_count + WIDTH'(1);
        gray_next = bin_next ^ (bin_next >> 1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bin_count  <= '0;
            gray_count <= '0;
        end else begin
            bin_count  <= bin_next;
            gray_count <= gray_next;
        end
    end

`ifdef GR_BIN_COUNTER_TC_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tc <= 1'b0;
        end else begin
            tc <= (bin_next == {WIDTH{1'b1}});
        end
    end
`endif

endmodule

// File: tb/tb_gr_bin_counter.sv
// Scoreboard bench: stimulus pushes expected outputs per cycle, a negedge monitor pops and compares.
module tb_gr_bin_counter;

    logic       clk;
    logic       rst;
    logic [3:0] gray4, bin4;
    logic [5:0] gray6, bin6;
`ifdef GR_BIN_COUNTER_TC_EN
    logic       tc4, tc6;
`endif

    gr_bin_counter #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .gray_count(gray4), .bin_count(bin4)
`ifdef GR_BIN_COUNTER_TC_EN
        , .tc(tc4)
`endif
    );

    gr_bin_counter #(.WIDTH(6)) dut6 (
        .clk(clk), .rst(rst), .gray_count(gray6), .bin_count(bin6)
`ifdef GR_BIN_COUNTER_TC_EN
        , .tc(tc6)
`endif
    );

    initial begin
        clk = 1'b1;
        forever #5 clk = ~clk;
    end

    typedef struct packed {
        logic [3:0] g4;
        logic [3:0] b4;
        logic [5:0] g6;
        logic [5:0] b6;
        logic       tc4;
        logic       tc6;
        logic       hchk;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    logic [31:0] mcnt;
    logic        hchk_en;

    // Hand-written 4-bit reflected Gray sequence indexed by binary count.
    localparam logic [3:0] GTAB [16] = '{
        4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100,
        4'b1100, 4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001, 4'b1000
    };

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h want %0h", nm, $time, act, exp);
        end
    endtask

    task automatic push_exp();
        exp_t e;
        logic [5:0] b6;
        b6     = mcnt[5:0];
        e.b4   = mcnt[3:0];
        e.g4   = GTAB[mcnt[3:0]];
        e.b6   = b6;
        e.g6   = b6 ^ (b6 >> 1);
        e.tc4  = (mcnt[3:0] == 4'hF);
        e.tc6  = (b6 == 6'h3F);
        e.hchk = hchk_en;
        q.push_back(e);
    endtask

    // One clock: the model follows the edge using the rst level it saw, then rst is
    // changed 1ns later (between edges) so an assertion must clear outputs at once.
    task automatic cyc(input logic r);
        @(posedge clk);
        if (rst) mcnt = 0;
        else     mcnt = mcnt + 1;
        #1;
        rst = r;
        if (r) mcnt = 0;
        push_exp();
    endtask

    logic [3:0] prev_g4;

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk("gray4", 32'(gray4), 32'(e.g4));
            chk("bin4",  32'(bin4),  32'(e.b4));
            chk("gray6", 32'(gray6), 32'(e.g6));
            chk("bin6",  32'(bin6),  32'(e.b6));
`ifdef GR_BIN_COUNTER_TC_EN
            chk("tc4", 32'(tc4), 32'(e.tc4));
            chk("tc6", 32'(tc6), 32'(e.tc6));
`endif
            if (e.hchk) chk("hamming4", 32'($countones(prev_g4 ^ gray4)), 32'd1);
        end
        prev_g4 <= gray4;
    end

    initial begin
        rst     = 1'b0;
        mcnt    = 0;
        hchk_en = 1'b0;
        #1;
        // Reset asserted before any clock edge; checked at the first negedge.
        rst = 1'b1;
        push_exp();
        cyc(1'b1);
        cyc(1'b1);
        // Release and count 8: gray 0001..1100, bin 8.
        cyc(1'b0);
        repeat (8) cyc(1'b0);
        // Mid-cycle reset, then 10 counts -> gray 1111, bin 10.
        cyc(1'b1);
        cyc(1'b0);
        repeat (10) cyc(1'b0);
        // Full 16-step sequence through the 4-bit wrap with Hamming checks,
        // then continue past the 6-bit wrap at 64.
        cyc(1'b1);
        cyc(1'b0);
        hchk_en = 1'b1;
        repeat (16) cyc(1'b0);
        hchk_en = 1'b0;
        repeat (50) cyc(1'b0);
        cyc(1'b1);
        cyc(1'b1);
        // Drain the scoreboard with a bounded wait.
        for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
        #2;
        if (q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: got %0d pending want 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
